// File: rtl/ray_setup_if.sv
// ray_setup_if: ray payload and valid/ready handshake between the ray
// generator (master) and the DDA stepper (slave).
interface ray_setup_if;
    logic        valid_out;
    logic        ready_in;
    logic [10:0] hcount_ray_out;
    logic [1:0]  step_out;
    logic [31:0] rayDir_out;
    logic [31:0] sideDist_out;
    logic [31:0] deltaDist_out;
    logic [13:0] map_out;

    modport master (
        output valid_out,
        output hcount_ray_out,
        output step_out,
        output rayDir_out,
        output sideDist_out,
        output deltaDist_out,
        output map_out,
        input  ready_in
    );

    modport slave (
        input  valid_out,
        input  hcount_ray_out,
        input  step_out,
        input  rayDir_out,
        input  sideDist_out,
        input  deltaDist_out,
        input  map_out,
        output ready_in
    );
endinterface

// File: rtl/ray_setup.sv
// ray_setup: per-frame ray generator for the DDA stepper, one ray per column.
// Build option: define RAY_SETUP_PARALLEL_DIV_EN to run the X and Y
// deltaDist dividers concurrently (single 17-cycle DIV phase, 20-cycle
// latency); otherwise one shared divider runs X then Y (37-cycle latency).
module ray_setup #(
    parameter int unsigned SCREEN_WIDTH = 320,
    parameter int unsigned CAM_STEP     = 32768 / SCREEN_WIDTH
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        frame_start_in,
    input  logic [31:0] pos_in,
    input  logic [31:0] dir_in,
    input  logic [31:0] plane_in,
    output logic        busy_out,
    output logic        frame_done_out,
    ray_setup_if.master ray
);

    localparam int unsigned HC_W     = 11;
    localparam int unsigned MAP_W    = 14;
    localparam int unsigned DIV_LAST = 16;
`ifdef RAY_SETUP_PARALLEL_DIV_EN
    localparam int unsigned LANES    = 2;
`else
    localparam int unsigned LANES    = 1;
`endif
    localparam logic [15:0]     CAM_START = 16'hC000;
    localparam logic [16:0]     DIV_NUM   = 17'h10000;
    localparam logic [HC_W-1:0] HC_LAST   = HC_W'(SCREEN_WIDTH - 1);
    localparam logic [15:0]     CAM_INC   = 16'(CAM_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAM,
        S_DIV_X,
        S_DIV_Y,
        S_SIDE,
        S_OUT
    } state_t;

    // Saturate a signed value to signed 16 bits.
    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'h7FFF;
        end else if (v < -32'sd32768) begin
            return 16'h8000;
        end
        return v[15:0];
    endfunction

    // Magnitude of a signed 16-bit value; -32768 maps to 32768.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? 16'(~v + 16'd1) : v;
    endfunction

    // One restoring-division step: returns {remainder, dividend/quotient shift reg}.
    function automatic logic [32:0] div_step(input logic [15:0] rem,
                                             input logic [16:0] num,
                                             input logic [15:0] den);
        logic [16:0] w_trial;
        logic        w_q;
        w_trial = {rem, num[16]};
        w_q     = (w_trial >= {1'b0, den});
        return {(w_q ? 16'(w_trial - {1'b0, den}) : w_trial[15:0]), num[15:0], w_q};
    endfunction

    // Distance from the pose to the first grid line along one axis.
    function automatic logic [15:0] side_dist(input logic        neg,
                                              input logic [7:0]  frac,
                                              input logic [15:0] delta);
        logic [8:0]  w_mul;
        logic [24:0] w_prod;
        w_mul  = neg ? {1'b0, frac} : (9'd256 - {1'b0, frac});
        w_prod = (25'(w_mul) * 25'(delta)) >> 8;
        if (delta == 16'hFFFF || w_prod > 25'h00FFFF) begin
            return 16'hFFFF;
        end
        return w_prod[15:0];
    endfunction

    state_t          r_state;
    logic [15:0]     r_dir_x, r_dir_y, r_plane_x, r_plane_y;
    logic [7:0]      r_frac_x, r_frac_y;
    logic [MAP_W-1:0] r_map;
    logic [15:0]     r_cam;
    logic [HC_W-1:0] r_hcount;
    logic [15:0]     r_ray_x, r_ray_y;
    logic [15:0]     r_delta_x, r_delta_y;
    logic [4:0]      r_div_cnt;
    logic [15:0]     r_div_rem [LANES];
    logic [16:0]     r_div_num [LANES];
    logic [15:0]     r_div_den [LANES];

    logic            r_valid;
    logic            r_busy;
    logic            r_frame_done;
    logic [HC_W-1:0] r_o_hcount;
    logic [1:0]      r_o_step;
    logic [31:0]     r_o_ray_dir;
    logic [31:0]     r_o_side;
    logic [31:0]     r_o_delta;
    logic [MAP_W-1:0] r_o_map;

    logic signed [31:0] w_prod_x, w_prod_y;
    logic [15:0]        w_ray_x, w_ray_y;
    logic [32:0]        w_step [LANES];
    logic [15:0]        w_quo  [LANES];
    logic               w_unused;

    // Integer bit of the Q8.8 position above 127 does not reach the map index.
    assign w_unused = &{1'b0, pos_in[31], pos_in[15]};

    // Camera-plane ray direction for the current column.
    assign w_prod_x = 32'($signed(r_plane_x)) * 32'($signed(r_cam));
    assign w_prod_y = 32'($signed(r_plane_y)) * 32'($signed(r_cam));
    assign w_ray_x  = r_dir_x + sat16(w_prod_x >>> 14);
    assign w_ray_y  = r_dir_y + sat16(w_prod_y >>> 14);

    // Next divider step per lane and the saturated quotient it completes.
    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            w_step[l] = div_step(r_div_rem[l], r_div_num[l], r_div_den[l]);
            w_quo[l]  = (r_div_den[l] == 16'd0 || w_step[l][16]) ? 16'hFFFF
                                                                 : w_step[l][15:0];
        end
    end

    // Frame sequencer, divider datapath and registered ray payload.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= S_IDLE;
            r_dir_x      <= '0;
            r_dir_y      <= '0;
            r_plane_x    <= '0;
            r_plane_y    <= '0;
            r_frac_x     <= '0;
            r_frac_y     <= '0;
            r_map        <= '0;
            r_cam        <= '0;
            r_hcount     <= '0;
            r_ray_x      <= '0;
            r_ray_y      <= '0;
            r_delta_x    <= '0;
            r_delta_y    <= '0;
            r_div_cnt    <= '0;
            for (int l = 0; l < int'(LANES); l++) begin
                r_div_rem[l] <= '0;
                r_div_num[l] <= '0;
                r_div_den[l] <= '0;
            end
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_o_hcount   <= '0;
            r_o_step     <= '0;
            r_o_ray_dir  <= '0;
            r_o_side     <= '0;
            r_o_delta    <= '0;
            r_o_map      <= '0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (frame_start_in) begin
                        r_dir_x   <= dir_in[31:16];
                        r_dir_y   <= dir_in[15:0];
                        r_plane_x <= plane_in[31:16];
                        r_plane_y <= plane_in[15:0];
                        r_frac_x  <= pos_in[23:16];
                        r_frac_y  <= pos_in[7:0];
                        r_map     <= {pos_in[30:24], pos_in[14:8]};
                        r_cam     <= CAM_START;
                        r_hcount  <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CAM;
                    end
                end
                S_CAM: begin
                    r_ray_x      <= w_ray_x;
                    r_ray_y      <= w_ray_y;
                    r_div_cnt    <= '0;
                    r_div_rem[0] <= '0;
                    r_div_num[0] <= DIV_NUM;
                    r_div_den[0] <= abs16(w_ray_x);
`ifdef RAY_SETUP_PARALLEL_DIV_EN
                    r_div_rem[1] <= '0;
                    r_div_num[1] <= DIV_NUM;
                    r_div_den[1] <= abs16(w_ray_y);
`endif
                    r_state      <= S_DIV_X;
                end
                S_DIV_X: begin
                    for (int l = 0; l < int'(LANES); l++) begin
                        r_div_rem[l] <= w_step[l][32:17];
                        r_div_num[l] <= w_step[l][16:0];
                    end
                    r_div_cnt <= r_div_cnt + 5'd1;
                    if (r_div_cnt == 5'(DIV_LAST)) begin
                        r_delta_x <= w_quo[0];
`ifdef RAY_SETUP_PARALLEL_DIV_EN
                        r_delta_y <= w_quo[1];
                        r_state   <= S_SIDE;
`else
                        r_div_cnt    <= '0;
                        r_div_rem[0] <= '0;
                        r_div_num[0] <= DIV_NUM;
                        r_div_den[0] <= abs16(r_ray_y);
                        r_state      <= S_DIV_Y;
`endif
                    end
                end
`ifndef RAY_SETUP_PARALLEL_DIV_EN
                S_DIV_Y: begin
                    r_div_rem[0] <= w_step[0][32:17];
                    r_div_num[0] <= w_step[0][16:0];
                    r_div_cnt    <= r_div_cnt + 5'd1;
                    if (r_div_cnt == 5'(DIV_LAST)) begin
                        r_delta_y <= w_quo[0];
                        r_state   <= S_SIDE;
                    end
                end
`endif
                S_SIDE: begin
                    r_o_hcount  <= r_hcount;
                    r_o_step    <= {~r_ray_x[15], ~r_ray_y[15]};
                    r_o_ray_dir <= {r_ray_x, r_ray_y};
                    r_o_side    <= {side_dist(r_ray_x[15], r_frac_x, r_delta_x),
                                    side_dist(r_ray_y[15], r_frac_y, r_delta_y)};
                    r_o_delta   <= {r_delta_x, r_delta_y};
                    r_o_map     <= r_map;
                    r_valid     <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (ray.ready_in) begin
                        r_valid  <= 1'b0;
                        r_cam    <= r_cam + CAM_INC;
                        r_hcount <= r_hcount + HC_W'(1);
                        if (r_hcount == HC_LAST) begin
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_state <= S_CAM;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ray.valid_out      = r_valid;
    assign ray.hcount_ray_out = r_o_hcount;
    assign ray.step_out       = r_o_step;
    assign ray.rayDir_out     = r_o_ray_dir;
    assign ray.sideDist_out   = r_o_side;
    assign ray.deltaDist_out  = r_o_delta;
    assign ray.map_out        = r_o_map;
    assign busy_out           = r_busy;
    assign frame_done_out     = r_frame_done;

endmodule

// File: tb/tb_ray_setup.sv
// tb_ray_setup: randomized frames checked against an arithmetic ray model.
module tb_ray_setup;
    localparam int unsigned W        = 320;
    localparam int unsigned CAM_STEP = 32768 / W;
`ifdef RAY_SETUP_PARALLEL_DIV_EN
    localparam int LAT = 20;
`else
    localparam int LAT = 37;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [31:0] pos = '0, dir = '0, plane = '0;
    logic        busy, frame_done;

    ray_setup_if bus();

    ray_setup #(.SCREEN_WIDTH(W), .CAM_STEP(CAM_STEP)) dut (
        .pixel_clk_in  (clk),
        .rst_n_in      (rst_n),
        .frame_start_in(frame_start),
        .pos_in        (pos),
        .dir_in        (dir),
        .plane_in      (plane),
        .busy_out      (busy),
        .frame_done_out(frame_done),
        .ray           (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected ray for one column, straight from the arithmetic definitions.
    function automatic logic [122:0] m_ray(input logic [31:0] p, input logic [31:0] d,
                                           input logic [31:0] pl, input int col);
        int          cam;
        int          ray [2];
        int          dl  [2];
        int          sd  [2];
        int          fr  [2];
        logic [15:0] d16 [2];
        logic [15:0] p16 [2];
        logic [15:0] r16;
        cam    = -16384 + col * int'(CAM_STEP);
        d16[0] = d[31:16];  d16[1] = d[15:0];
        p16[0] = pl[31:16]; p16[1] = pl[15:0];
        fr[0]  = int'(p[23:16]);
        fr[1]  = int'(p[7:0]);
        for (int a = 0; a < 2; a++) begin
            longint prod;
            int     sh;
            int     mag;
            int     m;
            prod = longint'($signed(p16[a])) * longint'(cam);
            sh   = int'(prod >>> 14);
            if (sh > 32767) sh = 32767;
            if (sh < -32768) sh = -32768;
            r16    = 16'(int'($signed(d16[a])) + sh);
            ray[a] = int'($signed(r16));
            mag    = (ray[a] < 0) ? -ray[a] : ray[a];
            dl[a]  = (mag == 0) ? 65535 : 65536 / mag;
            if (dl[a] > 65535) dl[a] = 65535;
            m      = (ray[a] < 0) ? fr[a] : 256 - fr[a];
            sd[a]  = (dl[a] == 65535) ? 65535 : (m * dl[a]) / 256;
            if (sd[a] > 65535) sd[a] = 65535;
        end
        return {11'(col), 1'(ray[0] >= 0), 1'(ray[1] >= 0),
                16'(ray[0]), 16'(ray[1]), 16'(sd[0]), 16'(sd[1]),
                16'(dl[0]), 16'(dl[1]), p[30:24], p[14:8]};
    endfunction

    // Run one frame, scoring every valid cycle against the model stream.
    task automatic run_frame(input string name, input logic [31:0] p, input logic [31:0] d,
                             input logic [31:0] pl, input int ready_pct, input int hold_col,
                             input bit col0, input bit zero_y, input bit inject);
        logic [122:0] exp_q[$];
        logic [122:0] obs;
        int got = 0, n = 0, first_v = -1, done_cnt = 0, hold_cnt = 0, post = 0;
        for (int c = 0; c < int'(W); c++) exp_q.push_back(m_ray(p, d, pl, c));
        @(posedge clk); #1;
        pos = p; dir = d; plane = pl; frame_start = 1'b1;
        bus.ready_in = (hold_col == 0) ? 1'b0 : ($urandom_range(99) < ready_pct);
        while (n < 25000 && post < 4) begin
            @(negedge clk);
            if (bus.valid_out) begin
                obs = {bus.hcount_ray_out, bus.step_out, bus.rayDir_out,
                       bus.sideDist_out, bus.deltaDist_out, bus.map_out};
                if (first_v < 0) begin
                    first_v = n;
                    check_eq({name, "_latency"}, 128'(n), 128'(LAT));
                    check_eq({name, "_busy_mid"}, 128'(busy), 128'(1));
                    if (col0) begin
                        check_eq({name, "_c0_raydir"}, 128'(bus.rayDir_out), 128'(32'hFF57_0100));
                        check_eq({name, "_c0_delta"}, 128'(bus.deltaDist_out), 128'(32'h0183_0100));
                        check_eq({name, "_c0_step"}, 128'(bus.step_out), 128'(2'b01));
                        check_eq({name, "_c0_side"}, 128'(bus.sideDist_out), 128'(32'h00C1_0080));
                        check_eq({name, "_c0_map"}, 128'(bus.map_out), 128'({7'd12, 7'd12}));
                        check_eq({name, "_c0_hcount"}, 128'(bus.hcount_ray_out), 128'(0));
                    end
                end
                if (got < int'(W)) begin
                    check_eq({name, "_ray"}, 128'(obs), 128'(exp_q[got]));
                end else begin
                    check_eq({name, "_extra_valid"}, 128'(got), 128'(W - 1));
                end
                if (zero_y) begin
                    check_eq({name, "_zero_y"},
                             128'({bus.rayDir_out[15:0], bus.deltaDist_out[15:0],
                                   bus.sideDist_out[15:0], bus.step_out[0]}),
                             128'({16'h0000, 16'hFFFF, 16'hFFFF, 1'b1}));
                end
                if (bus.ready_in) got++;
                else if (got == hold_col) hold_cnt++;
            end
            if (frame_done) done_cnt++;
            if (got >= int'(W)) post++;
            @(posedge clk); #1;
            frame_start  = inject && (n == 400);
            bus.ready_in = (got == hold_col && hold_cnt < 10) ? 1'b0
                                                               : ($urandom_range(99) < ready_pct);
            n++;
        end
        frame_start = 1'b0;
        check_eq({name, "_transfers"}, 128'(got), 128'(W));
        check_eq({name, "_frame_done"}, 128'(done_cnt), 128'(1));
        check_eq({name, "_hold_cycles"}, 128'(hold_cnt), 128'((hold_col >= 0) ? 10 : 0));
        check_eq({name, "_busy_end"}, 128'(busy), 128'(0));
    endtask

    initial begin
        int seen_valid, seen_busy;
        bus.ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs",
                 128'({bus.valid_out, busy, frame_done, bus.hcount_ray_out, bus.step_out,
                       bus.rayDir_out, bus.sideDist_out, bus.deltaDist_out, bus.map_out}),
                 128'(0));
        rst_n = 1'b1;

        run_frame("directed", 32'h0C80_0C80, 32'h0000_0100, 32'h00A9_0000, 100, 0, 1'b1, 1'b0, 1'b0);
        run_frame("zero_ray", 32'h0380_0540, 32'h0100_0000, 32'h0000_0000, 70, -1, 1'b0, 1'b1, 1'b0);
        run_frame("rand_a", $urandom, $urandom, $urandom, 100, -1, 1'b0, 1'b0, 1'b1);
        run_frame("rand_b", $urandom, {16'($urandom_range(1023)), 16'($urandom)},
                  $urandom, 85, 7, 1'b0, 1'b0, 1'b0);

        // Reset asserted while the divider is working on column 0.
        @(posedge clk); #1;
        pos = 32'h0C80_0C80; dir = 32'h0000_0100; plane = 32'h00A9_0000;
        frame_start = 1'b1; bus.ready_in = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_eq("rst_busy_before", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_outputs",
                 128'({bus.valid_out, busy, frame_done, bus.hcount_ray_out, bus.step_out,
                       bus.rayDir_out, bus.sideDist_out, bus.deltaDist_out, bus.map_out}),
                 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_valid = 0;
        seen_busy  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.valid_out) seen_valid++;
            if (busy || frame_done) seen_busy++;
        end
        check_eq("rst_no_valid", 128'(seen_valid), 128'(0));
        check_eq("rst_idle_busy", 128'(seen_busy), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
